mem_wb_lsu: RTL
===============

// Module: mem_wb_lsu
// PURPOSE
//  Load/store stage: EX/MEM pipeline register, data-memory req/ready master, and MEM/WB register.
//  Drives the forwarding sources back into EX: ALUResult_mem/rdAddr_mem/RegWrite_mem
//  and RegWriteData_wb/rdAddr_wb/RegWrite_wb. Also drives mem_stall to freeze IF/ID/EX
//  while a data access is outstanding.
// PARAMETERS
//  TIMEOUT   16   max ACCESS cycles without dmem_ready before bus_err; 0 = no timeout
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous active-low reset
//  valid_ex        in   1   EX holds a real instruction (0 = bubble)
//  ALUResult_ex    in   32  ALU result / effective address
//  MemWriteData_ex in   32  forwarded rs2 store data
//  rdAddr_ex       in   5   destination register
//  RegWrite_ex     in   1   instruction writes rd
//  MemRead_ex      in   1   load
//  MemWrite_ex     in   1   store (MemRead_ex&MemWrite_ex never both 1)
//  MemSize_ex      in   2   00 byte, 01 half, 10 word (11 treated as word)
//  MemUnsigned_ex  in   1   1 = zero-extend load (LBU/LHU)
//  ALUResult_mem   out  32  EX/MEM result (forward source)
//  rdAddr_mem      out  5   EX/MEM rd
//  RegWrite_mem    out  1   EX/MEM write enable, 0 when rd==0 or bubble
//  RegWriteData_wb out  32  MEM/WB write-back data (load data or ALU result)
//  rdAddr_wb       out  5   MEM/WB rd
//  RegWrite_wb     out  1   MEM/WB write enable
//  mem_stall       out  1   hold upstream stages and EX/MEM this cycle
//  dmem_req        out  1   access request
//  dmem_we         out  1   1 = store
//  dmem_addr       out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_be         out  4   byte enables
//  dmem_wdata      out  32  lane-replicated store data
//  dmem_ready      in   1   access completes this cycle (may be combinational from req)
//  dmem_rdata      in   32  read data, valid when dmem_ready
//  misalign_err    out  1   1-cycle pulse: misaligned access dropped
//  bus_err         out  1   1-cycle pulse: TIMEOUT reached, access abandoned
// BEHAVIOUR
//  Reset: all registers, outputs 0; state IDLE; dmem_req drops asynchronously.
//  advance = !mem_stall. On advance: EX/MEM <= EX inputs (bubble if !valid_ex) and MEM/WB <= MEM result.
//  States:
//   IDLE: entered whenever EX/MEM holds a non-memory op or a bubble.
//   ACCESS: entered when a mem op is captured with legal alignment.
//   IDLE->ACCESS happens on capture of an aligned load/store. Misaligned
//    (half addr[0]!=0; word addr[1:0]!=0) stays IDLE: no req, misalign_err pulses the cycle after capture.
//   In ACCESS: dmem_req=1, with addr/we/be/wdata stable until ready.
//   mem_stall = ACCESS & !dmem_ready (timeout excluded).
//   ACCESS exits when dmem_ready=1 (->IDLE, or ->ACCESS if the next captured op is mem) or on timeout.
//  Latency: zero-wait memory (ready same cycle) = 1 cycle in MEM, no stall; N wait cycles = N stall cycles.
//  Timeout: counter counts ACCESS cycles with !ready. When it reaches TIMEOUT-1 with ready=0:
//    bus_err pulses, mem_stall=0, access abandoned, RegWrite_wb=0 for that instruction. Counter clears on exit.
//  Store lanes: byte be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}; half be=addr[1]?1100:0011,
//    wdata={2{d[15:0]}}; word be=1111, wdata=d.
//  Load: byte rdata[8*addr[1:0]+:8], half rdata[16*addr[1]+:16]; sign-extend unless MemUnsigned.
//  RegWriteData_wb = load ? extended rdata : ALUResult_mem, captured on the advance edge.
//  Load/error gating: misaligned or errored loads write nothing (RegWrite_wb=0). Stores never write rd.
//  During stall: MEM/WB captures a bubble (RegWrite_wb=0), so WB is not written twice.
//  Simultaneous ready and timeout: ready wins, no bus_err.
//  Reset mid-ACCESS: request abandoned, no write-back.
// TESTING
//  1. ALU op x5<=0x1234, valid, no mem -> next cycle ALUResult_mem=0x1234, rdAddr_mem=5, RegWrite_mem=1;
//     one cycle later RegWriteData_wb=0x1234, no dmem_req.
//  2. SB d=0xA5 addr 0x103, ready tied 1 -> dmem_be=1000, wdata=0xA5A5A5A5, addr=0x100, we=1, mem_stall never 1.
//  3. LH signed addr 0x202, rdata=0x8001_0000, ready after 3 cycles -> mem_stall high 3 cycles;
//     RegWriteData_wb=0xFFFF8001; LHU gives 0x00008001.
//  4. LW addr 0x301 -> no dmem_req, misalign_err 1-cycle pulse, RegWrite_wb stays 0.
//  5. TIMEOUT=16, LW with ready held 0 -> stall 15 cycles, bus_err pulse, pipeline resumes, no write-back.
//  6. rst_n low mid-ACCESS -> dmem_req, mem_stall, all reg outputs 0 immediately; after release IDLE;
//     rd=x0 ALU op -> RegWrite_mem=0.

Source files
------------

// File: rtl/mem_wb_lsu.sv
// rtl/mem_wb_lsu.sv - load/store stage: EX/MEM register, data-memory master, MEM/WB register
module mem_wb_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [1:0]  MemSize_ex,
  input  logic        MemUnsigned_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  logic [31:0] alu_q, alu_d, wd_q, wd_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d, ld_q, ld_d, st_q, st_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;

  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;

  logic [CW-1:0] cnt_q, cnt_d;

  logic        in_access, tmo, stall, mis, ex_access;
  logic [3:0]  be;
  logic [31:0] wdata, rshift, load_val;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Only an aligned memory op captured on an advance edge starts a bus access.
  always_comb begin
    state_d = state_q;
    if (!stall) state_d = ex_access ? ACCESS : IDLE;
  end

  always_comb begin
    in_access = (state_q == ACCESS);
    tmo       = in_access & !dmem_ready & (TIMEOUT != 0) & (cnt_q == CW'(TIMEOUT - 1));
    stall     = in_access & !dmem_ready & !tmo;
    dmem_req  = in_access;
    dmem_we   = in_access & st_q;
    dmem_addr = in_access ? {alu_q[31:2], 2'b00} : 32'h0;
    dmem_be   = in_access ? be : 4'h0;
    dmem_wdata = in_access ? wdata : 32'h0;
    mem_stall = stall;
    bus_err   = tmo;
  end

  always_comb begin
    ex_access = valid_ex & (MemRead_ex | MemWrite_ex) &
                !misaligned(MemSize_ex, ALUResult_ex[1:0]);
    mis = (ld_q | st_q) & misaligned(size_q, alu_q[1:0]);
  end

  always_comb begin
    be    = 4'hF;
    wdata = wd_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << alu_q[1:0];
        wdata = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be    = alu_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rshift   = dmem_rdata >> {alu_q[1:0], 3'b000};
    load_val = dmem_rdata;
    case (size_q)
      2'b00:   load_val = {{24{!uns_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_val = {{16{!uns_q & rshift[15]}}, rshift[15:0]};
      default: ;
    endcase
  end

  // EX/MEM holds while stalled; a bubble is captured as all-zero fields.
  always_comb begin
    alu_d  = alu_q;
    wd_d   = wd_q;
    rd_d   = rd_q;
    rw_d   = rw_q;
    ld_d   = ld_q;
    st_d   = st_q;
    size_d = size_q;
    uns_d  = uns_q;
    if (!stall) begin
      alu_d  = valid_ex ? ALUResult_ex : 32'h0;
      wd_d   = valid_ex ? MemWriteData_ex : 32'h0;
      rd_d   = valid_ex ? rdAddr_ex : 5'd0;
      rw_d   = valid_ex & RegWrite_ex & (rdAddr_ex != 5'd0);
      ld_d   = valid_ex & MemRead_ex;
      st_d   = valid_ex & MemWrite_ex;
      size_d = valid_ex ? MemSize_ex : 2'b00;
      uns_d  = valid_ex & MemUnsigned_ex;
    end
  end

  always_comb begin
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = 1'b0;
    if (!stall) begin
      wb_we_d   = rw_q & !st_q & !(ld_q & (mis | tmo));
      wb_rd_d   = rd_q;
      wb_data_d = ld_q ? load_val : alu_q;
    end
    cnt_d = stall ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q     <= '0;
      wd_q      <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      alu_q     <= alu_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ALUResult_mem   = alu_q;
  assign rdAddr_mem      = rd_q;
  assign RegWrite_mem    = rw_q;
  assign RegWriteData_wb = wb_data_q;
  assign rdAddr_wb       = wb_rd_q;
  assign RegWrite_wb     = wb_we_q;
  assign misalign_err    = mis;

endmodule
